// File: rtl/pp_pix_rd_drain.sv
// Read-side engine of the pixel ping-pong RAM: reads one filled buffer and streams it out
// through a 2-entry FIFO with sof/eof tags. Optional frame counter: PP_PIX_RD_FRAME_CNT_EN.
module pp_pix_rd_drain #(
  parameter int VA = 500,
  parameter int AW = 9,
  parameter int DW = 509
) (
  input  logic          clk_i,
  input  logic          resetz_i,
  input  logic          enable_i,
  input  logic          pp_ram_empty_i,
  output logic          pp_ram_rd_done_o,
  output logic [AW-1:0] pix_raddr_o,
  output logic          pix_rd_o,
  input  logic [DW-1:0] pix_rdata_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_sof_o,
  output logic          out_eof_o,
  output logic          busy_o,
  output logic [15:0]   frame_cnt_o
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, DONE, SETTLE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_q;
  logic            tag_sof_q, tag_eof_q;
  logic [DW+1:0]   fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      occ_q;
  logic            pop, push, last_addr;
  logic [2:0]      demand;

  assign last_addr        = (addr_q == AW'(VA - 1));
  assign out_valid_o      = (occ_q != 2'd0);
  assign pop              = out_valid_o & out_ready_i;
  assign push             = rd_q;
  assign {out_data_o, out_sof_o, out_eof_o} = fifo_q[rd_ptr_q];
  assign demand           = {1'b0, occ_q} + {2'b0, rd_q};
  assign pp_ram_rd_done_o = (state_q == DONE);
  assign busy_o           = (state_q != IDLE);
  assign pix_raddr_o      = addr_q;

  // A read is only issued when its word is guaranteed a FIFO slot on arrival.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pix_rd_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && !pp_ram_empty_i) begin
          state_d = READ;
          addr_d  = '0;
        end
      end
      READ: begin
        if (demand < (3'd2 + {2'b0, pop})) begin
          pix_rd_o = 1'b1;
          if (last_addr) state_d = DRAIN;
          else           addr_d  = addr_q + AW'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetz_i) begin
    if (!resetz_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      tag_sof_q <= 1'b0;
      tag_eof_q <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= pix_rd_o;
      if (pix_rd_o) begin
        tag_sof_q <= (addr_q == '0);
        tag_eof_q <= last_addr;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {pix_rdata_i, tag_sof_q, tag_eof_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef PP_PIX_RD_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk_i or negedge resetz_i) begin
    if (!resetz_i)              frame_cnt_q <= 16'd0;
    else if (pp_ram_rd_done_o)  frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt_o = frame_cnt_q;
`else
  assign frame_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pp_pix_rd_drain.sv
// Self-checking bench for pp_pix_rd_drain: frame-level scoreboard plus a table of
// enable/empty/backpressure scenarios and a hand-written reset-abort sequence.
module tb_pp_pix_rd_drain;
  localparam int VA = 500;
  localparam int AW = 9;
  localparam int DW = 509;

  logic          clk_i = 1'b0;
  logic          resetz_i;
  logic          enable_i;
  logic          pp_ram_empty_i;
  logic          pp_ram_rd_done_o;
  logic [AW-1:0] pix_raddr_o;
  logic          pix_rd_o;
  logic [DW-1:0] pix_rdata_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          out_sof_o;
  logic          out_eof_o;
  logic          busy_o;
  logic [15:0]   frame_cnt_o;

  pp_pix_rd_drain #(.VA(VA), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .resetz_i(resetz_i), .enable_i(enable_i),
    .pp_ram_empty_i(pp_ram_empty_i), .pp_ram_rd_done_o(pp_ram_rd_done_o),
    .pix_raddr_o(pix_raddr_o), .pix_rd_o(pix_rd_o), .pix_rdata_i(pix_rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_sof_o(out_sof_o), .out_eof_o(out_eof_o), .busy_o(busy_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic en;
    logic empty;
    int   frames;
    int   drop_word;
    int   stop_mode;
    int   ready_mode;
    int   exp_done;
  } vec_t;

  vec_t vecs[8];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every word is unique per (buffer release count, address) so reorder/loss/duplication shows up.
  function automatic logic [DW-1:0] make_word(input int f, input int a);
    logic [31:0] h;
    h = (f * 32'h9E3779B1) ^ (a * 32'h85EBCA6B) ^ 32'h5A5A0F0F;
    return {f[15:0], a[15:0], {14{h}}, h[28:0] ^ a[28:0]};
  endfunction

  int ready_mode = 0;
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      case (ready_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ~out_ready_i;
        default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int ram_frame = 0;
  always @(posedge clk_i) begin
    if (pix_rd_o) pix_rdata_i <= make_word(ram_frame, int'(pix_raddr_o));
    else          pix_rdata_i <= make_word(int'($urandom), int'($urandom));
    if (pp_ram_rd_done_o) ram_frame <= ram_frame + 1;
  end

  int issued, accepted, rd_idx, exp_idx, exp_frame, run_len, max_run;
  int done_cnt = 0, done_total = 0, start_cnt = 0, words_cnt = 0;
  logic          busy_prev, have_stall;
  logic [DW-1:0] stall_data;
  logic [1:0]    stall_tags;

  // Reference: each released buffer is VA words at addresses 0..VA-1, streamed in order.
  always @(negedge clk_i) begin
    if (!resetz_i) begin
      issued = 0; accepted = 0; rd_idx = 0; exp_idx = 0; exp_frame = ram_frame;
      run_len = 0; done_total = 0; busy_prev = 1'b0; have_stall = 1'b0;
    end else begin
      if (have_stall) begin
        check_output("stall_valid", DW'(out_valid_o), DW'(1));
        check_output("stall_data", out_data_o, stall_data);
        check_output("stall_tags", DW'({out_sof_o, out_eof_o}), DW'(stall_tags));
      end
      have_stall = out_valid_o && !out_ready_i;
      stall_data = out_data_o;
      stall_tags = {out_sof_o, out_eof_o};
      if (pix_rd_o) begin
        check_output("rd_addr", DW'(pix_raddr_o), DW'(rd_idx));
        issued++; rd_idx++; run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (pp_ram_rd_done_o) begin
        check_output("done_after_reads", DW'(rd_idx), DW'(VA));
        rd_idx = 0; done_cnt++; done_total++;
      end
      if (out_valid_o && out_ready_i) begin
        check_output("out_data", out_data_o, make_word(exp_frame, exp_idx));
        check_output("out_tags", DW'({out_sof_o, out_eof_o}), DW'({exp_idx == 0, exp_idx == VA - 1}));
        accepted++; words_cnt++; exp_idx++;
        if (exp_idx == VA) begin exp_idx = 0; exp_frame++; end
      end
      if (pix_rd_o || (out_valid_o && out_ready_i))
        check_output("outstanding_le2", DW'((issued - accepted) <= 2), DW'(1));
      if (busy_o && !busy_prev) start_cnt++;
      busy_prev = busy_o;
    end
  end

  task automatic check_all_zero(input string p);
    check_output({p, "_rd"},    DW'(pix_rd_o), '0);
    check_output({p, "_raddr"}, DW'(pix_raddr_o), '0);
    check_output({p, "_valid"}, DW'(out_valid_o), '0);
    check_output({p, "_data"},  out_data_o, '0);
    check_output({p, "_tags"},  DW'({out_sof_o, out_eof_o}), '0);
    check_output({p, "_done"},  DW'(pp_ram_rd_done_o), '0);
    check_output({p, "_busy"},  DW'(busy_o), '0);
    check_output({p, "_fcnt"},  DW'(frame_cnt_o), '0);
  endtask

  task automatic check_frame_cnt(input string name);
`ifdef PP_PIX_RD_FRAME_CNT_EN
    check_output(name, DW'(frame_cnt_o), DW'(16'(done_total)));
`else
    check_output(name, DW'(frame_cnt_o), '0);
`endif
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    int d0, w0, s0, busy_seen;
    bit stopped;
    d0 = done_cnt; w0 = words_cnt; s0 = start_cnt;
    @(posedge clk_i); #1;
    ready_mode = v.ready_mode; enable_i = v.en; pp_ram_empty_i = v.empty; max_run = 0;
    stopped = (v.frames == 0);
    for (int cyc = 0; cyc < 4000 * (v.frames + 1); cyc++) begin
      @(posedge clk_i); #1;
      if (!stopped && (start_cnt - s0) >= v.frames && rd_idx >= v.drop_word) begin
        stopped = 1'b1;
        if (v.stop_mode == 0) enable_i = 1'b0;
        else                  pp_ram_empty_i = 1'b1;
      end
      if (stopped && cyc >= 30 && !busy_o && !out_valid_o) break;
    end
    check_output($sformatf("v%0d_idle", idx), DW'({busy_o, out_valid_o}), '0);
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (busy_o) busy_seen++;
    end
    check_output($sformatf("v%0d_stay_idle", idx), DW'(busy_seen), '0);
    check_output($sformatf("v%0d_done_cnt", idx), DW'(done_cnt - d0), DW'(v.exp_done));
    check_output($sformatf("v%0d_words", idx), DW'(words_cnt - w0), DW'(v.exp_done * VA));
    if (v.ready_mode == 0 && v.exp_done > 0)
      check_output($sformatf("v%0d_rd_run", idx), DW'(max_run), DW'(VA));
    check_frame_cnt($sformatf("v%0d_frame_cnt", idx));
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, w0;
    //          en    empty frames drop stop ready exp_done
    vecs[0] = '{1'b1, 1'b0, 1,     0,   0,   0,    1};
    vecs[1] = '{1'b1, 1'b0, 3,     0,   0,   0,    3};
    vecs[2] = '{1'b1, 1'b0, 1,     100, 0,   1,    1};
    vecs[3] = '{1'b0, 1'b0, 0,     0,   0,   0,    0};
    vecs[4] = '{1'b1, 1'b1, 0,     0,   0,   2,    0};
    vecs[5] = '{1'b1, 1'b0, 1,     50,  1,   2,    1};
    vecs[6] = '{1'b1, 1'b0, 2,     300, 0,   2,    2};
    vecs[7] = '{1'b1, 1'b0, 1,     100, 0,   0,    1};

    resetz_i = 1'b0; enable_i = 1'b0; pp_ram_empty_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 check_all_zero("reset");
    @(negedge clk_i) resetz_i = 1'b1;

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], i);

    // Reset in the middle of a frame: no release, then the same buffer restarts at address 0.
    d0 = done_cnt;
    ready_mode = 0; enable_i = 1'b1; pp_ram_empty_i = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk_i); #1;
      if (rd_idx >= 250) break;
    end
    check_output("rst_reached_250", DW'(rd_idx >= 250), DW'(1));
    resetz_i = 1'b0;
    #1 check_all_zero("rst_async");
    repeat (3) @(negedge clk_i);
    check_all_zero("rst_held");
    check_output("rst_no_done", DW'(done_cnt - d0), '0);
    w0 = words_cnt;
    resetz_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (pix_rd_o) break;
    end
    check_output("rst_restart_rd", DW'(pix_rd_o), DW'(1));
    check_output("rst_restart_addr", DW'(pix_raddr_o), '0);
    @(posedge clk_i); #1 enable_i = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_i); #1;
      if (!busy_o && !out_valid_o) break;
    end
    check_output("rst_after_idle", DW'({busy_o, out_valid_o}), '0);
    check_output("rst_after_done", DW'(done_cnt - d0), DW'(1));
    check_output("rst_after_words", DW'(words_cnt - w0), DW'(VA));
    check_frame_cnt("rst_after_frame_cnt");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/pp_pix_rd_drain.md
Name: pp_pix_rd_drain

Overview:
- Read-side engine for the pixel ping-pong RAM controller (depth-4 pp_ram, VA words of 509 bits per buffer).
- While the ping-pong RAM reports a filled buffer, it sequences read addresses 0..VA-1 and captures the 1-cycle-latency read data.
- It streams the words downstream on a valid/ready interface with first/last markers, then pulses the read-done strobe that releases the buffer back to the writer.

Parameters:
- VA, 500, words per buffer (frame); legal 2..2^AW.
- AW, 9, read address width.
- DW, 509, pixel word width.

Ports:
- clk_i  in  1  clock.
- resetz_i  in  1  asynchronous active-low reset.
- enable_i  in  1  allow starting new frames; level-sensitive.
- pp_ram_empty_i  in  1  high = no filled buffer available.
- pp_ram_rd_done_o  out  1  one-cycle pulse, releases the current buffer.
- pix_raddr_o  out  AW  RAM read address.
- pix_rd_o  out  1  RAM read strobe; data returns on pix_rdata_i the next cycle.
- pix_rdata_i  in  DW  RAM read data.
- out_valid_o  out  1  downstream word valid.
- out_ready_i  in  1  downstream accept.
- out_data_o  out  DW  pixel word.
- out_sof_o  out  1  high with word 0 of a frame.
- out_eof_o  out  1  high with word VA-1 of a frame.
- busy_o  out  1  high in any state other than IDLE.
- frame_cnt_o  out  16  completed-frame counter (optional feature).

Behaviour:
- Reset (asynchronous, resetz_i low):
  - State is IDLE.
  - All outputs are 0: pix_raddr_o, pix_rd_o, out_* , pp_ram_rd_done_o, busy_o, frame_cnt_o.
  - Output buffer is emptied; in-flight read is discarded.
  - No rd_done pulse is issued for a frame aborted by reset.
- State machine:
  - IDLE: enable_i=1 and pp_ram_empty_i=0 → READ; the read address counter is cleared to 0.
  - READ: issue reads (rule below). The address increments on each issued read. When the read of address VA-1 is issued → DRAIN.
  - DRAIN: wait for the last read data to be captured into the output buffer (1 cycle) → DONE.
  - DONE: pp_ram_rd_done_o=1 for exactly one cycle → SETTLE.
  - SETTLE: one idle cycle so the updated empty flag is visible → IDLE.
- Output buffer:
  - 2-entry registered FIFO holding {data, sof, eof}; out_* are driven from the head entry.
  - Push on the cycle after pix_rd_o. Pop when out_valid_o & out_ready_i.
- Read issue rule: pix_rd_o=1 in READ iff occ + inflight - pop < 2, where:
  - occ = buffer entries (0..2),
  - inflight = pix_rd_o from the previous cycle,
  - pop = the current handshake.
  - This guarantees no overflow and 1 word/cycle under continuous out_ready_i.
- Latency: pix_rd_o first rises in the cycle after IDLE→READ. Word 0 appears on out_valid_o 2 cycles after its pix_rd_o.
- Backpressure:
  - out_valid_o stays high with data, sof and eof held stable until accepted.
  - Reads stall; the address holds.
- rd_done is released after the last word is captured, not after it is accepted. The buffer may be refilled while the tail words are still downstream.
- A new frame may start from IDLE while the buffer is non-empty. Consecutive frames keep word ordering. sof/eof are tagged per word.
- enable_i=0 mid-frame: the current frame completes fully, including rd_done; no new frame starts.
- pp_ram_empty_i is sampled only in IDLE; changes in other states are ignored.
- Address arithmetic is AW bits; the counter never exceeds VA-1.

Optional Feature:
- Macro PP_PIX_RD_FRAME_CNT_EN.
- Defined: frame_cnt_o increments by 1 on each pp_ram_rd_done_o pulse, wraps 0xFFFF→0x0000, and resets to 0.
- Undefined: frame_cnt_o is constant 0 and no counter logic is synthesized.

Test Plan:
- Continuous ready, VA=500, empty_i low:
  - rd_done pulses once;
  - 500 words are output in order with sof on word 0 and eof on word 499;
  - pix_rd_o is high on 500 consecutive cycles.
- out_ready_i toggling 1-0-1-0 → no word lost or duplicated, out_data_o stable while stalled, occ never exceeds 2.
- empty_i held low across 3 frames with continuous ready → 3 rd_done pulses, each followed by SETTLE then a new READ; 1500 words with 3 sof/eof pairs.
- resetz_i asserted at word 250 → all outputs 0 immediately, no rd_done; after release with empty_i low, the frame restarts at address 0.
- enable_i dropped at word 100 → frame completes (500 words, 1 rd_done), then stays IDLE with busy_o=0.
- With PP_PIX_RD_FRAME_CNT_EN, counter preloaded via 65535 frames (or forced) → next rd_done wraps frame_cnt_o to 0. Without the macro, frame_cnt_o stays 0.
